// File: rtl/ahb5_random_subordinate.sv
// AHB5 subordinate with 16 words, access-rule checks and two-cycle ERROR responses.
// Define AHB5_RESP_WAIT_STATES_EN to add LFSR-driven wait states; otherwise OKAY transfers are zero-wait.
module ahb5_random_subordinate #(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [7:0]  LFSR_SEED = 8'hA5
) (
   input  logic        HCLK,
   input  logic        HRESET,
   input  logic        HSEL,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic        HWRITE,
   input  logic [2:0]  HSIZE,
   input  logic [2:0]  HBURST,
   input  logic        HMASTLOCK,
   input  logic [3:0]  HPROT,
   input  logic        HNONSEC,
   input  logic [31:0] HWDATA,
   input  logic        HREADY,
   output logic        HREADYOUT,
   output logic        HRESP,
   output logic [31:0] HRDATA,
   output logic [15:0] xfer_count,
   output logic [15:0] err_count
);

   typedef enum logic [1:0] {IDLE, WAIT, ERR1, ERR2} state_t;

   state_t      state_q, state_d;
   logic        dp_act_q, dp_act_d;
   logic        dp_wr_q, dp_wr_d;
   logic [3:0]  dp_idx_q, dp_idx_d;
   logic [1:0]  dp_size_q, dp_size_d;
   logic [1:0]  dp_lo_q, dp_lo_d;
   logic [1:0]  wait_q, wait_d;
   logic [15:0] xfer_q, xfer_d;
   logic [15:0] err_q, err_d;
   logic [31:0] mem_q [16];
   logic [31:0] mem_d [16];
   logic [1:0]  wait_init;
   logic        accept, acc_err, commit;
   logic [3:0]  lane_en;
   logic        unused_inputs;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   function automatic logic [3:0] lanes(input logic [1:0] size, input logic [1:0] lo);
      logic [3:0] en;
      case (size)
         2'd0:    en = 4'b0001 << lo;
         2'd1:    en = lo[1] ? 4'b1100 : 4'b0011;
         default: en = 4'b1111;
      endcase
      return en;
   endfunction

   // Upper half of the window is secure-only; word 0 is writable only by privileged masters.
   function automatic logic xfer_err(input logic [31:0] addr, input logic [2:0] size,
                                     input logic wr, input logic priv, input logic nonsec);
      logic out_rgn, bad_size, misalign, sec_hit, priv_hit;
      out_rgn  = (addr[31:6] != BASE_ADDR[31:6]);
      bad_size = (size > 3'b010);
      misalign = ((size == 3'b001) && addr[0]) || ((size == 3'b010) && (addr[1:0] != 2'b00));
      sec_hit  = nonsec && addr[5];
      priv_hit = wr && !priv && (addr[5:2] == 4'd0);
      return out_rgn || bad_size || misalign || sec_hit || priv_hit;
   endfunction

`ifdef AHB5_RESP_WAIT_STATES_EN
   logic [7:0] lfsr_q, lfsr_d;

   always_comb lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

   always_ff @(posedge HCLK) begin
      if (HRESET) lfsr_q <= LFSR_SEED;
      else        lfsr_q <= lfsr_d;
   end

   assign wait_init = lfsr_q[1:0];
`else
   assign wait_init = 2'd0;
`endif

   assign unused_inputs = ^{HBURST, HMASTLOCK, HPROT[3:2], HPROT[0]};
   assign accept        = HSEL && HTRANS[1] && HREADY;
   assign acc_err       = xfer_err(HADDR, HSIZE, HWRITE, HPROT[1], HNONSEC);
   assign lane_en       = lanes(dp_size_q, dp_lo_q);
   assign HRDATA        = (dp_act_q && !dp_wr_q) ? mem_q[dp_idx_q] : 32'd0;
   assign xfer_count    = xfer_q;
   assign err_count     = err_q;

   always_comb begin
      state_d   = state_q;
      dp_act_d  = dp_act_q;
      dp_wr_d   = dp_wr_q;
      dp_idx_d  = dp_idx_q;
      dp_size_d = dp_size_q;
      dp_lo_d   = dp_lo_q;
      wait_d    = wait_q;
      xfer_d    = xfer_q;
      err_d     = err_q;
      HREADYOUT = 1'b1;
      HRESP     = 1'b0;
      commit    = 1'b0;
      case (state_q)
         IDLE: begin
            if (dp_act_q) begin
               commit   = dp_wr_q;
               xfer_d   = sat_inc(xfer_q);
               dp_act_d = 1'b0;
            end
         end
         WAIT: begin
            HREADYOUT = 1'b0;
            wait_d    = wait_q - 2'd1;
            if (wait_q == 2'd1) state_d = IDLE;
         end
         ERR1: begin
            HREADYOUT = 1'b0;
            HRESP     = 1'b1;
            state_d   = ERR2;
         end
         ERR2: begin
            HRESP   = 1'b1;
            err_d   = sat_inc(err_q);
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // A new address phase overrides the completion bookkeeping of the previous one.
      if (accept) begin
         if (acc_err) begin
            state_d = ERR1;
         end else begin
            dp_act_d  = 1'b1;
            dp_wr_d   = HWRITE;
            dp_idx_d  = HADDR[5:2];
            dp_size_d = HSIZE[1:0];
            dp_lo_d   = HADDR[1:0];
            wait_d    = wait_init;
            state_d   = (wait_init != 2'd0) ? WAIT : IDLE;
         end
      end
   end

   always_comb begin
      mem_d = mem_q;
      if (commit) begin
         for (int b = 0; b < 4; b++) begin
            if (lane_en[b]) mem_d[dp_idx_q][8*b +: 8] = HWDATA[8*b +: 8];
         end
      end
   end

   always_ff @(posedge HCLK) begin
      if (HRESET) begin
         state_q  <= IDLE;
         dp_act_q <= 1'b0;
         wait_q   <= 2'd0;
         xfer_q   <= 16'd0;
         err_q    <= 16'd0;
         for (int i = 0; i < 16; i++) mem_q[i] <= 32'd0;
      end else begin
         state_q  <= state_d;
         dp_act_q <= dp_act_d;
         wait_q   <= wait_d;
         xfer_q   <= xfer_d;
         err_q    <= err_d;
         mem_q    <= mem_d;
      end
   end

   always_ff @(posedge HCLK) begin
      dp_wr_q   <= dp_wr_d;
      dp_idx_q  <= dp_idx_d;
      dp_size_q <= dp_size_d;
      dp_lo_q   <= dp_lo_d;
   end

endmodule

// File: tb/tb_ahb5_random_subordinate.sv
// Bench for ahb5_random_subordinate: directed and random AHB transfers against a byte-addressed model.
module tb_ahb5_random_subordinate;

   localparam logic [31:0] BASE = 32'h4000_0100;
   localparam logic [7:0]  SEED = 8'hA5;

   typedef struct packed {
      logic        wr;
      logic [31:0] addr;
      logic [2:0]  size;
      logic [3:0]  prot;
      logic        ns;
      logic [31:0] wdata;
   } xfer_t;

   logic        HCLK = 1'b0;
   logic        HRESET, HSEL, HWRITE, HMASTLOCK, HNONSEC, HREADY;
   logic [31:0] HADDR, HWDATA, HRDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic        HREADYOUT, HRESP;
   logic [15:0] xfer_count, err_count;

   logic [7:0]  mdl [64];
   logic [7:0]  tb_lfsr = 8'h00;
   xfer_t       seq [$];
   int          checks = 0;
   int          errors = 0;
   int          exp_xfer, exp_err;
   logic [31:0] last_rdata;

   always #5 HCLK = ~HCLK;
   assign HREADY = HREADYOUT;

   ahb5_random_subordinate #(.BASE_ADDR(BASE), .LFSR_SEED(SEED)) dut (
      .HCLK(HCLK), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
      .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST), .HMASTLOCK(HMASTLOCK),
      .HPROT(HPROT), .HNONSEC(HNONSEC), .HWDATA(HWDATA), .HREADY(HREADY),
      .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
      .xfer_count(xfer_count), .err_count(err_count)
   );

   // Reference sequence generator for x^8+x^6+x^5+x^4+1, one step per clock.
   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], ^(v & 8'hB8)};
   endfunction

   always @(posedge HCLK) tb_lfsr <= HRESET ? SEED : lfsr_step(tb_lfsr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic xfer_t mk(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                                input logic [3:0] prot, input logic ns, input logic [31:0] wdata);
      xfer_t t;
      t.wr = wr; t.addr = addr; t.size = size; t.prot = prot; t.ns = ns; t.wdata = wdata;
      return t;
   endfunction

   function automatic bit is_err(input xfer_t t);
      longint off;
      off = longint'(t.addr) - longint'(BASE);
      if (off < 0 || off > 63) return 1'b1;
      if (t.size > 3'd2) return 1'b1;
      if ((off % (longint'(1) << t.size)) != 0) return 1'b1;
      if (t.ns && off >= 32) return 1'b1;
      if (t.wr && !t.prot[1] && off < 4) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic [31:0] model_word(input int off);
      int w;
      w = off - (off % 4);
      return {mdl[w+3], mdl[w+2], mdl[w+1], mdl[w]};
   endfunction

   function automatic int exp_wait(input logic [1:0] w);
`ifdef AHB5_RESP_WAIT_STATES_EN
      return int'(w);
`else
      return (w == 2'd3) ? 0 : 0;
`endif
   endfunction

   task automatic clear_model();
      for (int i = 0; i < 64; i++) mdl[i] = 8'h00;
      exp_xfer = 0;
      exp_err  = 0;
   endtask

   task automatic drive_addr(input xfer_t t);
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = t.addr; HWRITE = t.wr;
      HSIZE = t.size; HPROT = t.prot; HNONSEC = t.ns;
   endtask

   task automatic drive_idle();
      HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
   endtask

   // Issues the queued transfers pipelined: transfer i+1's address overlaps transfer i's data phase.
   task automatic run_seq();
      int n, low, off, nb;
      logic [1:0] wexp, wnext;
      bit e;
      n = seq.size();
      @(negedge HCLK);
      drive_addr(seq[0]);
      wnext = tb_lfsr[1:0];
      for (int i = 0; i < n; i++) begin
         @(posedge HCLK);
         #1;
         wexp   = wnext;
         e      = is_err(seq[i]);
         HWDATA = seq[i].wdata;
         if (i + 1 < n) drive_addr(seq[i+1]);
         else drive_idle();
         low = 0;
         @(negedge HCLK);
         while (!HREADYOUT && low < 8) begin
            chk("resp_in_stall", 32'(HRESP), 32'(e));
            low++;
            @(negedge HCLK);
         end
         chk("stall_cycles", 32'(low), e ? 32'd1 : 32'(exp_wait(wexp)));
         chk("resp_done", 32'(HRESP), 32'(e));
         off = int'(seq[i].addr - BASE);
         if (e) begin
            if (!seq[i].wr) chk("err_rdata", HRDATA, 32'd0);
            exp_err++;
         end else begin
            exp_xfer++;
            if (seq[i].wr) begin
               nb = 1 << seq[i].size;
               for (int k = 0; k < nb; k++)
                  mdl[off+k] = seq[i].wdata[8*((off+k)%4) +: 8];
            end else begin
               last_rdata = HRDATA;
               chk("rdata", HRDATA, model_word(off));
            end
         end
         if (i + 1 < n) wnext = tb_lfsr[1:0];
      end
      @(negedge HCLK);
      seq.delete();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int r, off, guard;
      xfer_t t;
      HRESET = 1'b1; HSEL = 1'b0; HADDR = 32'd0; HTRANS = 2'b00; HWRITE = 1'b0; HSIZE = 3'd0;
      HBURST = 3'd0; HMASTLOCK = 1'b0; HPROT = 4'h3; HNONSEC = 1'b0; HWDATA = 32'd0;
      last_rdata = 32'd0;
      clear_model();
      repeat (3) @(posedge HCLK);
      #1 HRESET = 1'b0;
      @(negedge HCLK);
      chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      chk("rst_hresp", 32'(HRESP), 32'd0);
      chk("rst_hrdata", HRDATA, 32'd0);
      chk("rst_xfer", 32'(xfer_count), 32'd0);
      chk("rst_err", 32'(err_count), 32'd0);

      // BUSY is not accepted: zero-wait OKAY, nothing counted
      HSEL = 1'b1; HTRANS = 2'b01; HADDR = BASE + 4; HWRITE = 1'b1;
      @(negedge HCLK);
      chk("busy_ready", 32'(HREADYOUT), 32'd1);
      chk("busy_resp", 32'(HRESP), 32'd0);
      chk("busy_xfer", 32'(xfer_count), 32'd0);
      drive_idle();

      seq.push_back(mk(1'b1, BASE + 8, 3'd2, 4'h3, 1'b0, 32'hDEADBEEF));
      seq.push_back(mk(1'b0, BASE + 8, 3'd2, 4'h3, 1'b0, 32'h0));
      run_seq();
      chk("word_rw_data", last_rdata, 32'hDEADBEEF);
      chk("word_rw_xfer", 32'(xfer_count), 32'd2);

      seq.push_back(mk(1'b1, BASE + 32'h0D, 3'd0, 4'h3, 1'b0, 32'h11225A44));
      seq.push_back(mk(1'b0, BASE + 32'h0C, 3'd2, 4'h3, 1'b0, 32'h0));
      run_seq();
      chk("byte_lane_word3", last_rdata, 32'h0000_5A00);

      seq.push_back(mk(1'b0, BASE + 8, 3'd3, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b0, BASE + 8, 3'd2, 4'h3, 1'b0, 32'h0));
      run_seq();
      chk("bad_size_errcnt", 32'(err_count), 32'd1);
      chk("bad_size_mem", last_rdata, 32'hDEADBEEF);

      seq.push_back(mk(1'b1, BASE + 32'h20, 3'd2, 4'h3, 1'b1, 32'h12345678));
      seq.push_back(mk(1'b1, BASE, 3'd2, 4'h1, 1'b0, 32'h87654321));
      seq.push_back(mk(1'b0, BASE + 32'h20, 3'd2, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b0, BASE, 3'd2, 4'h3, 1'b0, 32'h0));
      run_seq();
      chk("guard_errcnt", 32'(err_count), 32'd3);
      chk("guard_word0", last_rdata, 32'd0);

      // Misalignment, out-of-window, upper half-word lanes, privileged write
      seq.push_back(mk(1'b1, BASE + 32'h11, 3'd1, 4'h3, 1'b0, 32'hFFFF_FFFF));
      seq.push_back(mk(1'b0, BASE + 32'h12, 3'd2, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b0, BASE + 32'h40, 3'd2, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b0, BASE - 4, 3'd2, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b1, BASE + 32'h12, 3'd1, 4'h3, 1'b0, 32'hBEEF_0000));
      seq.push_back(mk(1'b1, BASE, 3'd2, 4'h2, 1'b0, 32'hA1B2C3D4));
      seq.push_back(mk(1'b0, BASE + 32'h10, 3'd2, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b0, BASE, 3'd2, 4'h3, 1'b1, 32'h0));
      run_seq();
      chk("mix_xfer", 32'(xfer_count), 32'(exp_xfer));
      chk("mix_err", 32'(err_count), 32'(exp_err));

      for (int k = 0; k < 40; k++) begin
         r = int'($urandom_range(0, 9));
         t.wr = 1'($urandom_range(0, 1));
         t.size = (r == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
         off = (r == 1) ? int'($urandom_range(64, 80)) : int'($urandom_range(0, 63));
         if (r > 3 && t.size < 3'd3) off = off - (off % (1 << t.size));
         t.addr = BASE + 32'(off);
         t.prot = 4'($urandom);
         t.ns = ($urandom_range(0, 3) == 0);
         t.wdata = $urandom;
         seq.push_back(t);
      end
      run_seq();
      chk("rand_xfer", 32'(xfer_count), 32'(exp_xfer));
      chk("rand_err", 32'(err_count), 32'(exp_err));

      for (int k = 0; k < 20; k++)
         seq.push_back(mk(1'b0, BASE + 32'(4 * $urandom_range(0, 15)), 3'd2, 4'h3, 1'b0, 32'h0));
      run_seq();
      chk("b2b_xfer", 32'(xfer_count), 32'(exp_xfer));

      // Reset in the data phase of a write drops the write
      @(negedge HCLK);
      guard = 0;
`ifdef AHB5_RESP_WAIT_STATES_EN
      while (tb_lfsr[1:0] == 2'd0 && guard < 20) begin
         @(negedge HCLK);
         guard++;
      end
`endif
      chk("rst_guard", 32'(guard < 20), 32'd1);
      drive_addr(mk(1'b1, BASE + 32'h14, 3'd2, 4'h3, 1'b0, 32'hCAFEF00D));
      @(posedge HCLK);
      #1;
      HWDATA = 32'hCAFEF00D;
      drive_idle();
      HRESET = 1'b1;
`ifdef AHB5_RESP_WAIT_STATES_EN
      @(negedge HCLK);
      chk("rst_in_wait", 32'(HREADYOUT), 32'd0);
`endif
      @(posedge HCLK);
      #1 HRESET = 1'b0;
      @(negedge HCLK);
      chk("midrst_ready", 32'(HREADYOUT), 32'd1);
      chk("midrst_resp", 32'(HRESP), 32'd0);
      chk("midrst_rdata", HRDATA, 32'd0);
      chk("midrst_xfer", 32'(xfer_count), 32'd0);
      chk("midrst_err", 32'(err_count), 32'd0);
      clear_model();
      seq.push_back(mk(1'b0, BASE + 32'h14, 3'd2, 4'h3, 1'b0, 32'h0));
      seq.push_back(mk(1'b0, BASE + 8, 3'd2, 4'h3, 1'b0, 32'h0));
      run_seq();
      chk("midrst_mem", last_rdata, 32'd0);
      chk("midrst_xfer2", 32'(xfer_count), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
